// File: rtl/md5_ctrl_pkg.sv
// md5_ctrl_pkg: shared state encoding, status bit positions and index-width helper for the MD5 search controller
package md5_ctrl_pkg;
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WARM  = 3'd1,
      ST_RUN   = 3'd2,
      ST_PAUSE = 3'd3,
      ST_DONE  = 3'd4
   } state_t;
   localparam int STAT_DONE    = 0;
   localparam int STAT_FOUND   = 1;
   localparam int STAT_WARMING = 2;
   localparam int STAT_RUNNING = 3;
   localparam int STAT_PAUSED  = 4;
   // A single channel still needs a 1-bit index port.
   function automatic int idx_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/md5_found_arb.sv
// md5_found_arb: lowest-index match priority encoder with capture register for index and candidate
//  clk, rst_n    clock, asynchronous active-low reset
//  clr           synchronous clear of the captured result
//  capture_en    load the current winner into index/value
//  ch_found      per-channel match flags
//  ch_candidate  per-channel candidates, ch i at [i*CAND_W +: CAND_W]
//  index, value  captured winner
//  hit           any channel currently reporting a match
module md5_found_arb #(
   parameter int CHANNELS = 4,
   parameter int CAND_W   = 32,
   parameter int IW       = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clr,
   input  logic                       capture_en,
   input  logic [CHANNELS-1:0]        ch_found,
   input  logic [CHANNELS*CAND_W-1:0] ch_candidate,
   output logic [IW-1:0]              index,
   output logic [CAND_W-1:0]          value,
   output logic                       hit
);
   logic [IW-1:0]     sel;
   logic [CAND_W-1:0] cand;
   assign hit = |ch_found;
   // Scan from the top down so the lowest set channel is the last to write.
   always_comb begin
      sel  = '0;
      cand = ch_candidate[CAND_W-1:0];
      for (int i = CHANNELS-1; i >= 0; i--)
         if (ch_found[i]) begin
            sel  = IW'(i);
            cand = ch_candidate[i*CAND_W +: CAND_W];
         end
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         index <= '0;
         value <= '0;
      end else if (clr) begin
         index <= '0;
         value <= '0;
      end else if (capture_en) begin
         index <= sel;
         value <= cand;
      end
endmodule

// File: rtl/md5_search_ctrl.sv
// md5_search_ctrl: VIO control/status hub sequencing CHANNELS parallel MD5 search drivers
//  CLK, CPU_RESETN   clock, asynchronous active-low reset
//  vio_enable        run/pause level
//  vio_soft_reset    soft reset request, rising edge acts
//  vio_load          target load request, rising edge acts
//  vio_target        target hash to capture
//  ch_warming/done/found/candidate  per-channel driver status
//  ch_target         registered target broadcast to all channels
//  ch_enable         replicated run enable
//  ch_rst_n          replicated active-low soft reset pulse
//  vio_status        {paused,running,warming,found,done}
//  vio_found_ch      winning channel index
//  vio_found_value   winning candidate
//  vio_cycles        saturating count of WARM/RUN cycles
module md5_search_ctrl
   import md5_ctrl_pkg::*;
#(
   parameter int CHANNELS   = 4,
   parameter int TARGET_W   = 128,
   parameter int CAND_W     = 32,
   parameter int CYC_W      = 48,
   parameter int RST_CYCLES = 4
) (
   input  logic                       CLK,
   input  logic                       CPU_RESETN,
   input  logic                       vio_enable,
   input  logic                       vio_soft_reset,
   input  logic                       vio_load,
   input  logic [TARGET_W-1:0]        vio_target,
   input  logic [CHANNELS-1:0]        ch_warming,
   input  logic [CHANNELS-1:0]        ch_done,
   input  logic [CHANNELS-1:0]        ch_found,
   input  logic [CHANNELS*CAND_W-1:0] ch_candidate,
   output logic [TARGET_W-1:0]        ch_target,
   output logic [CHANNELS-1:0]        ch_enable,
   output logic [CHANNELS-1:0]        ch_rst_n,
   output logic [4:0]                 vio_status,
   output logic [idx_w(CHANNELS)-1:0] vio_found_ch,
   output logic [CAND_W-1:0]          vio_found_value,
   output logic [CYC_W-1:0]           vio_cycles
);
   localparam int RW = $clog2(RST_CYCLES + 1);
   if (TARGET_W % 32 != 0) begin : g_bad_target_w
      $error("md5_search_ctrl: TARGET_W must be a multiple of 32");
   end
   state_t        state, state_n;
   logic          load_prev, srst_prev, target_valid, found, hit;
   logic [RW-1:0] rst_cnt;
   logic          load_edge, srst_edge, active, counting, capture, reload, clr;
   assign load_edge = vio_load & ~load_prev;
   assign srst_edge = vio_soft_reset & ~srst_prev;
   assign active    = state inside {ST_WARM, ST_RUN, ST_PAUSE};
   assign counting  = state inside {ST_WARM, ST_RUN};
   // A soft reset in the same cycle as a match discards the match.
   assign capture   = active & hit & ~srst_edge;
   assign reload    = load_edge & ~srst_edge & (state == ST_DONE);
   assign clr       = srst_edge | reload;
   assign ch_enable = {CHANNELS{counting}};
   assign ch_rst_n  = {CHANNELS{rst_cnt == '0}};
   always_comb begin
      vio_status               = '0;
      vio_status[STAT_PAUSED]  = state == ST_PAUSE;
      vio_status[STAT_RUNNING] = state == ST_RUN;
      vio_status[STAT_WARMING] = state == ST_WARM;
      vio_status[STAT_FOUND]   = found;
      vio_status[STAT_DONE]    = state == ST_DONE;
   end
   always_comb begin
      state_n = state;
      case (state)
         ST_IDLE:  if (target_valid && vio_enable && rst_cnt == '0) state_n = ST_WARM;
         ST_WARM:  state_n = !vio_enable ? ST_PAUSE : (|ch_warming ? ST_WARM : ST_RUN);
         ST_RUN:   state_n = &ch_done ? ST_DONE : (!vio_enable ? ST_PAUSE : ST_RUN);
         ST_PAUSE: if (vio_enable) state_n = |ch_warming ? ST_WARM : ST_RUN;
         ST_DONE:  if (load_edge) state_n = ST_IDLE;
         default:  state_n = ST_IDLE;
      endcase
      if (capture) state_n = ST_DONE;
      if (srst_edge) state_n = ST_IDLE;
   end
   always_ff @(posedge CLK or negedge CPU_RESETN)
      if (!CPU_RESETN) begin
         state        <= ST_IDLE;
         load_prev    <= 1'b0;
         srst_prev    <= 1'b0;
         target_valid <= 1'b0;
         found        <= 1'b0;
         rst_cnt      <= '0;
         ch_target    <= '0;
         vio_cycles   <= '0;
      end else begin
         state     <= state_n;
         load_prev <= vio_load;
         srst_prev <= vio_soft_reset;
         rst_cnt   <= srst_edge ? RW'(RST_CYCLES) : (rst_cnt != '0 ? rst_cnt - 1'b1 : rst_cnt);
         if (srst_edge)
            target_valid <= 1'b0;
         else if (load_edge && (state == ST_IDLE || state == ST_DONE)) begin
            ch_target    <= vio_target;
            target_valid <= 1'b1;
         end
         found      <= clr ? 1'b0 : (found | capture);
         vio_cycles <= clr ? '0 : ((counting && !(&vio_cycles)) ? vio_cycles + 1'b1 : vio_cycles);
      end
   md5_found_arb #(
      .CHANNELS(CHANNELS),
      .CAND_W  (CAND_W),
      .IW      (idx_w(CHANNELS))
   ) u_arb (
      .clk         (CLK),
      .rst_n       (CPU_RESETN),
      .clr         (clr),
      .capture_en  (capture),
      .ch_found    (ch_found),
      .ch_candidate(ch_candidate),
      .index       (vio_found_ch),
      .value       (vio_found_value),
      .hit         (hit)
   );
endmodule
